ride_input_conditioner: RTL and testbench

//  Front end for the raw reed-switch and mode-button inputs of the bicycle computer.

---
 rtl/ride_input_conditioner.sv | 177 +++++++++++++++++
 tb/tb_ride_input_conditioner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ride_input_conditioner.sv
// Conditions the raw reed-switch and mode-button pins: synchronise, debounce,
// then derive revolution pulses/period/standstill and short/long press events.
module ride_input_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int REED_DEBOUNCE = 4,
  parameter int REED_LOCKOUT  = 100,
  parameter int MODE_DEBOUNCE = 20,
  parameter int LONG_PRESS    = 2000,
  parameter int STALL_CYCLES  = 8000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 reed,
  input  logic                 mode,
  output logic                 reed_pulse,
  output logic [CNT_WIDTH-1:0] reed_period,
  output logic                 period_valid,
  output logic                 stalled,
  output logic                 mode_short,
  output logic                 mode_long,
  output logic [1:0]           mode_state
);

  localparam int RDB_W  = $clog2(REED_DEBOUNCE + 1);
  localparam int MDB_W  = $clog2(MODE_DEBOUNCE + 1);
  localparam int LOCK_W = $clog2(REED_LOCKOUT + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS + 1);

  localparam logic [RDB_W-1:0]     REED_DB_LAST = RDB_W'(REED_DEBOUNCE - 1);
  localparam logic [MDB_W-1:0]     MODE_DB_LAST = MDB_W'(MODE_DEBOUNCE - 1);
  localparam logic [LOCK_W-1:0]    LOCK_LOAD    = LOCK_W'(REED_LOCKOUT - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST    = HOLD_W'(LONG_PRESS - 2);
  localparam logic [CNT_WIDTH-1:0] STALL_MAX    = CNT_WIDTH'(STALL_CYCLES);

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_PRESS = 2'd1;
  localparam logic [1:0] M_LONG  = 2'd2;

  logic [SYNC_STAGES-1:0] reed_sync;
  logic [SYNC_STAGES-1:0] mode_sync;
  logic                   reed_s;
  logic                   mode_s;

  logic [RDB_W-1:0]       reed_db;
  logic                   reed_filt;
  logic                   reed_filt_d;
  logic [MDB_W-1:0]       mode_db;
  logic                   mode_filt;

  logic [LOCK_W-1:0]      lock_cnt;
  logic [CNT_WIDTH-1:0]   per_cnt;
  logic [CNT_WIDTH-1:0]   per_cnt_next;
  logic                   accept;

  logic [1:0]             m_state;
  logic [HOLD_W-1:0]      hold_cnt;

  assign reed_s     = reed_sync[SYNC_STAGES-1];
  assign mode_s     = mode_sync[SYNC_STAGES-1];
  assign mode_state = m_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reed_sync <= '0;
      mode_sync <= '0;
    end else begin
      reed_sync <= {reed_sync[SYNC_STAGES-2:0], reed};
      mode_sync <= {mode_sync[SYNC_STAGES-2:0], mode};
    end
  end

  // The filtered level only moves after N consecutive samples disagree with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reed_db     <= '0;
      reed_filt   <= 1'b0;
      reed_filt_d <= 1'b0;
      mode_db     <= '0;
      mode_filt   <= 1'b0;
    end else begin
      reed_filt_d <= reed_filt;
      if (reed_s == reed_filt) begin
        reed_db <= '0;
      end else if (reed_db == REED_DB_LAST) begin
        reed_filt <= reed_s;
        reed_db   <= '0;
      end else begin
        reed_db <= reed_db + 1'b1;
      end
      if (mode_s == mode_filt) begin
        mode_db <= '0;
      end else if (mode_db == MODE_DB_LAST) begin
        mode_filt <= mode_s;
        mode_db   <= '0;
      end else begin
        mode_db <= mode_db + 1'b1;
      end
    end
  end

  assign accept = reed_filt && !reed_filt_d && (lock_cnt == '0);

  always_comb begin
    per_cnt_next = per_cnt;
    if (accept) begin
      per_cnt_next = CNT_WIDTH'(1);
    end else if (per_cnt != STALL_MAX) begin
      per_cnt_next = per_cnt + 1'b1;
    end
  end

  // per_cnt restarts at 1 on the pulse edge so the captured value is the exact spacing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_cnt     <= '0;
      per_cnt      <= STALL_MAX;
      reed_pulse   <= 1'b0;
      period_valid <= 1'b0;
      reed_period  <= '0;
      stalled      <= 1'b1;
    end else begin
      reed_pulse   <= accept;
      period_valid <= accept && (per_cnt < STALL_MAX);
      if (accept && (per_cnt < STALL_MAX)) begin
        reed_period <= per_cnt;
      end
      if (accept) begin
        lock_cnt <= LOCK_LOAD;
      end else if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - 1'b1;
      end
      per_cnt <= per_cnt_next;
      stalled <= (per_cnt_next == STALL_MAX);
    end
  end

  // Release is tested before the long threshold, so a tie reports a short press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_state    <= M_IDLE;
      hold_cnt   <= '0;
      mode_short <= 1'b0;
      mode_long  <= 1'b0;
    end else begin
      mode_short <= 1'b0;
      mode_long  <= 1'b0;
      case (m_state)
        M_IDLE: begin
          if (mode_filt) begin
            m_state  <= M_PRESS;
            hold_cnt <= '0;
          end
        end
        M_PRESS: begin
          if (!mode_filt) begin
            mode_short <= 1'b1;
            m_state    <= M_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) begin
              mode_long <= 1'b1;
              m_state   <= M_LONG;
            end
          end
        end
        M_LONG: begin
          if (!mode_filt) begin
            m_state <= M_IDLE;
          end
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ride_input_conditioner.sv
// Bench for ride_input_conditioner: directed scenarios then random pin activity,
// every cycle compared against an event-time reference model.
module tb_ride_input_conditioner;

  localparam int SYNC    = 2;
  localparam int RDB     = 4;
  localparam int LOCKOUT = 100;
  localparam int MDB     = 20;
  localparam int LONG    = 2000;
  localparam int STALL   = 8000;
  localparam int CW      = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          reed  = 1'b0;
  logic          mode  = 1'b0;
  logic          reed_pulse;
  logic [CW-1:0] reed_period;
  logic          period_valid;
  logic          stalled;
  logic          mode_short;
  logic          mode_long;
  logic [1:0]    mode_state;

  ride_input_conditioner #(
    .SYNC_STAGES(SYNC), .REED_DEBOUNCE(RDB), .REED_LOCKOUT(LOCKOUT),
    .MODE_DEBOUNCE(MDB), .LONG_PRESS(LONG), .STALL_CYCLES(STALL), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .reed(reed), .mode(mode),
    .reed_pulse(reed_pulse), .reed_period(reed_period), .period_valid(period_valid),
    .stalled(stalled), .mode_short(mode_short), .mode_long(mode_long),
    .mode_state(mode_state)
  );

  always #5 clock = ~clock;

  int cmp_cnt  = 0;
  int fail_cnt = 0;
  int obs_pulses = 0, obs_valid = 0, obs_short = 0, obs_long = 0;
  int mdl_pulses = 0, mdl_valid = 0, mdl_short = 0, mdl_long = 0;

  // Reference model: edges are numbered from reset release; events are derived
  // from sample windows and the edge numbers of accepted pulses and presses.
  logic          exp_pulse = 1'b0, exp_valid = 1'b0, exp_stalled = 1'b1;
  logic          exp_short = 1'b0, exp_long = 1'b0;
  logic [CW-1:0] exp_period = '0;
  bit rq[$], mq[$], rwin[$], mwin[$];
  bit rf, mf, r_rose_prev, m_fall_prev, have_pulse, m_longed, rs, ms, r_new, m_new;
  int n, last_pulse, m_rise;

  function automatic bit all_differ(input bit w[$], input bit f, input int need);
    if (w.size() < need) return 1'b0;
    foreach (w[i]) if (w[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      rq.delete(); mq.delete(); rwin.delete(); mwin.delete();
      rf = 0; mf = 0; r_rose_prev = 0; m_fall_prev = 0; have_pulse = 0; m_longed = 0;
      n = 0; last_pulse = 0; m_rise = 0;
      exp_pulse = 0; exp_valid = 0; exp_stalled = 1; exp_short = 0; exp_long = 0;
      exp_period = '0;
    end else begin
      rq.push_back(reed);
      mq.push_back(mode);
      rs = (rq.size() > SYNC) ? rq.pop_front() : 1'b0;
      ms = (mq.size() > SYNC) ? mq.pop_front() : 1'b0;
      rwin.push_back(rs);
      if (rwin.size() > RDB) void'(rwin.pop_front());
      mwin.push_back(ms);
      if (mwin.size() > MDB) void'(mwin.pop_front());
      r_new = all_differ(rwin, rf, RDB) ? ~rf : rf;
      m_new = all_differ(mwin, mf, MDB) ? ~mf : mf;

      exp_pulse = r_rose_prev && (!have_pulse || (n - last_pulse >= LOCKOUT));
      exp_valid = 1'b0;
      if (exp_pulse) begin
        if (have_pulse && (n - last_pulse < STALL)) begin
          exp_valid  = 1'b1;
          exp_period = CW'(n - last_pulse);
        end
        last_pulse = n;
        have_pulse = 1'b1;
      end
      exp_stalled = !have_pulse || (n - last_pulse + 1 >= STALL);
      r_rose_prev = r_new && !rf;
      rf = r_new;

      exp_short = m_fall_prev && !m_longed;
      exp_long  = mf && (n - m_rise == LONG);
      if (exp_long) m_longed = 1'b1;
      m_fall_prev = !m_new && mf;
      if (m_new && !mf) begin
        m_rise   = n;
        m_longed = 1'b0;
      end
      mf = m_new;

      mdl_pulses += int'(exp_pulse);
      mdl_valid  += int'(exp_valid);
      mdl_short  += int'(exp_short);
      mdl_long   += int'(exp_long);
      n++;
    end
  end

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clock);
      cmp_cnt++;
      assert ({reed_pulse, period_valid, stalled, mode_short, mode_long, reed_period} ===
              {exp_pulse, exp_valid, exp_stalled, exp_short, exp_long, exp_period})
      else begin
        fail_cnt++;
        $error("FAIL cycle_check t=%0t obs p=%0b v=%0b st=%0b ms=%0b ml=%0b per=%0d exp p=%0b v=%0b st=%0b ms=%0b ml=%0b per=%0d",
               $time, reed_pulse, period_valid, stalled, mode_short, mode_long, reed_period,
               exp_pulse, exp_valid, exp_stalled, exp_short, exp_long, exp_period);
      end
      obs_pulses += int'(reed_pulse);
      obs_valid  += int'(period_valid);
      obs_short  += int'(mode_short);
      obs_long   += int'(mode_long);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    cmp_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int p0, v0, s0, l0, r_left, m_left;

    tick(3);
    check("rst_stalled", int'(stalled), 1);
    check("rst_period", int'(reed_period), 0);
    check("rst_pulse", int'(reed_pulse), 0);
    check("rst_short", int'(mode_short), 0);
    check("rst_long", int'(mode_long), 0);
    reset = 1'b0;
    tick(5);

    // Single clean revolution: pulse on the 7th edge counting the sampling edge.
    p0 = obs_pulses;
    reed = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("t1_latency", int'(reed_pulse), (k == SYNC + RDB) ? 1 : 0);
      check("t1_stalled", int'(stalled), (k < SYNC + RDB) ? 1 : 0);
    end
    tick(42);
    reed = 1'b0;
    tick(20);
    check("t1_once", obs_pulses - p0, 1);

    tick(STALL);
    check("stall_after_idle", int'(stalled), 1);

    // Four revolutions 500 cycles apart, starting from standstill.
    p0 = obs_pulses; v0 = obs_valid;
    for (int i = 0; i < 4; i++) begin
      reed = 1'b1; tick(20);
      reed = 1'b0; tick(480);
    end
    check("t2_pulses", obs_pulses - p0, 4);
    check("t2_valids", obs_valid - v0, 3);
    check("t2_period", int'(reed_period), 500);
    check("t2_stalled", int'(stalled), 0);

    // Short glitches are filtered; a re-hit inside the lockout is dropped.
    p0 = obs_pulses;
    for (int g = 1; g <= 3; g++) begin
      reed = 1'b1; tick(g);
      reed = 1'b0; tick(10);
    end
    reed = 1'b1; tick(30);
    reed = 1'b0; tick(30);
    reed = 1'b1; tick(20);
    reed = 1'b0; tick(100);
    check("t3_pulses", obs_pulses - p0, 1);

    tick(STALL);
    check("t4_stalled", int'(stalled), 1);
    p0 = obs_pulses; v0 = obs_valid;
    reed = 1'b1; tick(20);
    reed = 1'b0; tick(10);
    check("t4_pulse", obs_pulses - p0, 1);
    check("t4_no_valid", obs_valid - v0, 0);
    check("t4_unstalled", int'(stalled), 0);

    s0 = obs_short; l0 = obs_long;
    mode = 1'b1; tick(500);
    mode = 1'b0; tick(40);
    check("t5_short", obs_short - s0, 1);
    check("t5_short_nolong", obs_long - l0, 0);
    s0 = obs_short; l0 = obs_long;
    mode = 1'b1; tick(3000);
    mode = 1'b0; tick(40);
    check("t5_long", obs_long - l0, 1);
    check("t5_long_noshort", obs_short - s0, 0);

    // Reset in the middle of a press and of a reed debounce.
    mode = 1'b1; tick(300);
    reed = 1'b1; tick(3);
    reset = 1'b1;
    tick(4);
    check("t6_rst_stalled", int'(stalled), 1);
    check("t6_rst_pulse", int'(reed_pulse), 0);
    check("t6_rst_period", int'(reed_period), 0);
    check("t6_rst_long", int'(mode_long), 0);
    p0 = obs_pulses; v0 = obs_valid; l0 = obs_long; s0 = obs_short;
    reset = 1'b0;
    tick(2100);
    check("t6_new_long", obs_long - l0, 1);
    check("t6_new_pulse", obs_pulses - p0, 1);
    check("t6_no_valid", obs_valid - v0, 0);
    check("t6_no_short", obs_short - s0, 0);
    mode = 1'b0; reed = 1'b0;
    tick(50);

    // Random independent activity on both pins.
    r_left = 0; m_left = 0;
    for (int c = 0; c < 12000; c++) begin
      if (r_left == 0) begin
        reed = ~reed;
        r_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 400));
      end
      if (m_left == 0) begin
        mode = ~mode;
        m_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : int'($urandom_range(26, 2600));
      end
      r_left--;
      m_left--;
      tick(1);
    end
    tick(50);

    check("tot_pulses", obs_pulses, mdl_pulses);
    check("tot_valid", obs_valid, mdl_valid);
    check("tot_short", obs_short, mdl_short);
    check("tot_long", obs_long, mdl_long);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
